// File: rtl/logic_ctrl_pkg.sv
// Shared constants for the byte-serial logic sequencer: opcodes, FSM states, lane width.
// BYTE_LOGIC_XOR_EN enables opcode 10 (XOR); otherwise 10 and 11 are both unsupported.
package logic_ctrl_pkg;

   localparam int LANE_W = 8;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic op_supported(input logic [1:0] op);
      case (op)
         OP_AND, OP_OR: return 1'b1;
`ifdef BYTE_LOGIC_XOR_EN
         OP_XOR:        return 1'b1;
`endif
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/logic_slice_8.sv
// Combinational 8-bit logic slice; unsupported opcodes yield 0x00.
// The XOR path exists only when BYTE_LOGIC_XOR_EN is defined.
module logic_slice_8
   import logic_ctrl_pkg::*;
(
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  logic [1:0]        op,
   output logic [LANE_W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
`ifdef BYTE_LOGIC_XOR_EN
         OP_XOR:  y = a ^ b;
`endif
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/byte_serial_logic_ctrl.sv
// Sequencer computing WIDTH-bit bitwise logic one byte per cycle, LSB byte first, through one slice.
// BYTE_LOGIC_XOR_EN enables XOR for opcode 10.
module byte_serial_logic_ctrl
   import logic_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   localparam int NBYTES = WIDTH / LANE_W;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic             err_q, err_d;

   logic [LANE_W-1:0] a_lane [NBYTES];
   logic [LANE_W-1:0] b_lane [NBYTES];
   logic [LANE_W-1:0] slice_y;

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign a_lane[gi] = a_q[gi*LANE_W +: LANE_W];
      assign b_lane[gi] = b_q[gi*LANE_W +: LANE_W];
   end

   logic_slice_8 u_slice (
      .a  (a_lane[idx_q]),
      .b  (b_lane[idx_q]),
      .op (op_q),
      .y  (slice_y)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               op_d    = in_op;
               data_d  = '0;
               err_d   = !op_supported(in_op);
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NBYTES; i++) begin
               if (idx_q == IDX_W'(i)) data_d[i*LANE_W +: LANE_W] = slice_y;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_AND;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Handshake outputs depend only on state (plus reset masking of in_ready).
   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = data_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_byte_serial_logic_ctrl.sv
// Self-checking bench for byte_serial_logic_ctrl against a whole-word behavioural model.
// Honours BYTE_LOGIC_XOR_EN for the expected XOR behaviour.
module tb_byte_serial_logic_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'b00;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_err;

   int errors = 0;
   int checks = 0;

   byte_serial_logic_ctrl #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clock = ~clock;

   // Whole-word reference: {err, result}.
   function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00: return {1'b0, a & b};
         2'b01: return {1'b0, a | b};
`ifdef BYTE_LOGIC_XOR_EN
         2'b10: return {1'b0, a ^ b};
`endif
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drives one request and waits for out_valid; lat=99 flags a missing acceptance or result.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data, output logic err);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      in_op = op;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
      in_op = 2'($urandom_range(0, 3));
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!out_valid || w >= 20) lat = 99;
      data = out_data;
      err = out_err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++;
      if (out_data !== 32'h0 || out_err !== 1'b0) begin
         errors++; $display("FAIL reset_out got=%h/%b want=00000000/0", out_data, out_err);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
      $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_basic_or();
      int lat; logic [31:0] d; logic e;
      out_ready = 1'b1;
      do_op(2'b01, 32'h0F0F_00FF, 32'hF000_FF00, lat, d, e);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL or_latency got=%0d want=4", lat); end
      checks++;
      if (d !== 32'hFF0F_FFFF || e !== 1'b0) begin
         errors++; $display("FAIL or_result got=%h/%b want=ff0fffff/0", d, e);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL or_handoff got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      $display("basic_or: lat=%0d data=%h err=%b", lat, d, e);
   endtask

   task automatic test_and_stall();
      int lat; logic [31:0] d; logic e; int bad;
      out_ready = 1'b0;
      do_op(2'b00, 32'hDEAD_BEEF, 32'hFFFF_0000, lat, d, e);
      checks++;
      if (lat !== 4 || d !== 32'hDEAD_0000 || e !== 1'b0) begin
         errors++; $display("FAIL and_result got lat=%0d %h/%b want 4 dead0000/0", lat, d, e);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_data !== 32'hDEAD_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL and_stall_stable got %0d bad cycles want 0", bad); end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL and_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      $display("and_stall: data=%h bad=%0d", d, bad);
   endtask

   task automatic test_opcodes();
      int lat; logic [31:0] d; logic e; logic [32:0] exp;
      out_ready = 1'b1;
      do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, d, e);
      checks++;
      if (lat !== 4 || d !== 32'h0 || e !== 1'b1) begin
         errors++; $display("FAIL op11 got lat=%0d %h/%b want 4 00000000/1", lat, d, e);
      end
      $display("op11: data=%h err=%b", d, e);
      tick();
      do_op(2'b10, 32'hAAAA_AAAA, 32'hFFFF_0000, lat, d, e);
`ifdef BYTE_LOGIC_XOR_EN
      exp = {1'b0, 32'h5555_AAAA};
`else
      exp = {1'b1, 32'h0};
`endif
      checks++;
      if (lat !== 4 || {e, d} !== exp) begin
         errors++; $display("FAIL op10 got lat=%0d %h/%b want 4 %h/%b", lat, d, e, exp[31:0], exp[32]);
      end
      $display("op10: data=%h err=%b", d, e);
      tick();
   endtask

   task automatic test_isolation();
      int lat; logic [31:0] a, b; logic [32:0] exp; int extra;
      out_ready = 1'b1;
      a = $urandom;
      b = $urandom;
      exp = model(2'b01, a, b);
      in_op = 2'b01; in_a = a; in_b = b; in_valid = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_a = $urandom; in_b = $urandom; in_op = 2'b00; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      lat = 3;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat !== 4 || out_data !== exp[31:0] || out_err !== exp[32]) begin
         errors++; $display("FAIL isolation_result got lat=%0d %h/%b want 4 %h/%b", lat, out_data, out_err, exp[31:0], exp[32]);
      end
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL isolation_no_second got %0d busy cycles want 0", extra); end
      $display("isolation: data=%h exp=%h", out_data, exp[31:0]);
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] d; logic e;
      out_ready = 1'b1;
      in_op = 2'b01; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
         errors++; $display("FAIL midreset_clear got %b %h/%b want 0 00000000/0", out_valid, out_data, out_err);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_idle got in_ready=%b want 1", in_ready); end
      do_op(2'b01, 32'h1, 32'h2, lat, d, e);
      checks++;
      if (lat !== 4 || d !== 32'h3 || e !== 1'b0) begin
         errors++; $display("FAIL midreset_next got lat=%0d %h/%b want 4 00000003/0", lat, d, e);
      end
      $display("reset_mid: next data=%h", d);
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, b0, a1, b1; logic [32:0] e0, e1;
      int acc_t [2]; int n_acc; logic [32:0] got [$];
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      e0 = model(2'b00, a0, b0);
      e1 = model(2'b01, a1, b1);
      out_ready = 1'b1;
      n_acc = 0;
      in_op = 2'b00; in_a = a0; in_b = b0; in_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         logic took;
         took = in_valid && in_ready;
         if (took) begin acc_t[n_acc] = c; n_acc++; end
         tick();
         if (took && n_acc == 1) begin in_op = 2'b01; in_a = a1; in_b = b1; end
         if (took && n_acc == 2) in_valid = 1'b0;
         if (out_valid) got.push_back({out_err, out_data});
      end
      in_valid = 1'b0;
      checks++;
      if (n_acc != 2 || acc_t[1] - acc_t[0] != 6) begin
         errors++; $display("FAIL b2b_spacing got acc=%0d spacing=%0d want 2/6", n_acc, acc_t[1] - acc_t[0]);
      end
      checks++;
      if (got.size() != 2) begin
         errors++; $display("FAIL b2b_count got %0d results want 2", got.size());
      end else begin
         checks++;
         if (got[0] !== e0 || got[1] !== e1) begin
            errors++; $display("FAIL b2b_data got %h,%h want %h,%h", got[0], got[1], e0, e1);
         end
      end
      $display("back_to_back: spacing=%0d results=%0d", acc_t[1] - acc_t[0], got.size());
   endtask

   task automatic test_random();
      int lat; logic [31:0] a, b, d; logic e; logic [1:0] op; logic [32:0] exp; int stall, bad;
      for (int n = 0; n < 24; n++) begin
         a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
         stall = $urandom_range(0, 3);
         exp = model(op, a, b);
         out_ready = (stall == 0);
         do_op(op, a, b, lat, d, e);
         checks++;
         if (lat !== 4 || {e, d} !== exp) begin
            errors++; $display("FAIL random_%0d got lat=%0d %h/%b want 4 %h/%b", n, lat, d, e, exp[31:0], exp[32]);
         end
         bad = 0;
         for (int s = 0; s < stall; s++) begin
            tick();
            if (out_valid !== 1'b1 || {out_err, out_data} !== exp) bad++;
         end
         out_ready = 1'b1;
         tick();
         checks++;
         if (bad != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL random_hold_%0d got bad=%0d out_valid=%b want 0/0", n, bad, out_valid);
         end
         $display("random %0d: op=%0d a=%h b=%h data=%h err=%b stall=%0d", n, op, a, b, d, e, stall);
         out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic_or();
      test_and_stall();
      test_opcodes();
      test_isolation();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
